fetch_queue: RTL

- Parametrised successor to the single-PC fetch stage.
- Owns the PC, issues sequential instruction-memory reads, and buffers fetched {pc, instr} pairs in a DEPTH-entry FIFO, so decode stalls do not stall instruction memory.
- Applies redirects (branch / jr / j) from execute, flushing all buffered wrong-path entries.
- Sits between the icache/imem port and the IF/ID latch.

---
 rtl/fetch_queue_pkg.sv | 10 +
 rtl/fetch_queue_if.sv | 33 +++
 rtl/fetch_queue_fifo.sv | 42 ++++
 rtl/fetch_queue.sv | 58 +++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared fetch types (word, redirect kind, queued entry, fetch state).
package fetch_queue_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {Norm, Bran, PCJr, PCJ} pcsrc_t;
  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_entry_t;
  typedef enum logic {RUN, HALTED} fetch_state_t;
endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: imem port, execute redirect and decode dequeue signals of the fetch stage.
interface fetch_queue_if
  import fetch_queue_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int DEPTH = 4
);
  logic ihit;
  logic [WORD_W-1:0] imemload;
  logic iREN;
  logic [WORD_W-1:0] imemaddr;
  logic redir;
  pcsrc_t PCSrc;
  logic [WORD_W-1:0] redir_npc;
  logic [15:0] imm;
  logic [25:0] jaddr;
  logic [WORD_W-1:0] rdat1;
  logic halt;
  logic deq_ready;
  logic deq_valid;
  logic [WORD_W-1:0] deq_instr;
  logic [WORD_W-1:0] deq_pc;
  logic [WORD_W-1:0] deq_npc;
  logic [$clog2(DEPTH+1)-1:0] count;
  modport master (
    input ihit, imemload, redir, PCSrc, redir_npc, imm, jaddr, rdat1, halt, deq_ready,
    output iREN, imemaddr, deq_valid, deq_instr, deq_pc, deq_npc, count
  );
  modport slave (
    output ihit, imemload, redir, PCSrc, redir_npc, imm, jaddr, rdat1, halt, deq_ready,
    input iREN, imemaddr, deq_valid, deq_instr, deq_pc, deq_npc, count
  );
endinterface

// File: rtl/fetch_queue_fifo.sv
// fetch_fifo: registered FIFO of fetch entries with flush; head is visible the cycle after enqueue.
module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter type entry_t = fetch_entry_t,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH+1)
) (
  input  logic clk,
  input  logic rst,
  input  logic enq,
  input  logic deq,
  input  logic flush,
  input  entry_t wdata,
  output logic full,
  output logic empty,
  output logic [CW-1:0] count,
  output entry_t head
);
  entry_t mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic enq_ok, deq_ok;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign enq_ok = enq && !full;
  assign deq_ok = deq && !empty;
  assign head = mem[rptr];
  always_ff @(posedge clk)
    if (enq_ok && !flush)
      mem[wptr] <= wdata;
  always_ff @(posedge clk)
    if (rst || flush) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (enq_ok) wptr <= wptr + AW'(1);
      if (deq_ok) rptr <= rptr + AW'(1);
      count <= count + CW'(enq_ok) - CW'(deq_ok);
    end
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: PC owner that streams sequential imem reads into a FIFO for decode,
// flushing on execute redirects and stopping on halt.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter logic [31:0] PC_INIT = 32'h0,
  parameter int DEPTH = 4,
  parameter int WORD_W = 32
) (
  input logic CLK,
  input logic RST,
  fetch_queue_if.master bus
);
  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } entry_t;
  fetch_state_t state;
  logic [WORD_W-1:0] pc, target, bran_tgt, jmp_tgt;
  logic full, empty, ren;
  entry_t head;
  assign bran_tgt = bus.redir_npc + {{(WORD_W-18){bus.imm[15]}}, bus.imm, 2'b00};
  assign jmp_tgt = WORD_W'({bus.redir_npc[WORD_W-1 -: 4], bus.jaddr, 2'b00});
  always_comb
    target = bus.PCSrc == Bran ? bran_tgt :
             bus.PCSrc == PCJr ? bus.rdat1 :
             bus.PCSrc == PCJ  ? jmp_tgt : bus.redir_npc;
  assign ren = !RST && state == RUN && !full && !bus.redir && !bus.halt;
  always_ff @(posedge CLK)
    if (RST) begin
      pc <= WORD_W'(PC_INIT);
      state <= RUN;
    end else if (bus.redir) begin
      pc <= target;
      state <= RUN;
    end else if (state == RUN && bus.halt)
      state <= HALTED;
    else if (ren && bus.ihit)
      pc <= pc + WORD_W'(4);
  fetch_fifo #(.DEPTH(DEPTH), .entry_t(entry_t)) u_fifo (
    .clk(CLK),
    .rst(RST),
    .enq(ren && bus.ihit),
    .deq(bus.deq_ready),
    .flush(bus.redir),
    .wdata('{pc: pc, instr: bus.imemload}),
    .full(full),
    .empty(empty),
    .count(bus.count),
    .head(head)
  );
  assign bus.iREN = ren;
  assign bus.imemaddr = pc;
  assign bus.deq_valid = !empty;
  assign bus.deq_pc = head.pc;
  assign bus.deq_instr = head.instr;
  assign bus.deq_npc = head.pc + WORD_W'(4);
endmodule
